// File: rtl/io_pkg.sv
// Shared types and defaults for the IO decompressor row writer.
package io_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HEADER = 2'd1,
    ST_WRITE  = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  localparam int ADDR_W_DEF   = 10;
  localparam int CNN_BASE_DEF = 0;
  localparam int IMG_BASE_DEF = 2 ** (ADDR_W_DEF - 1);
  // The header length field is as wide as a memory address.
  localparam int HDR_LEN_W    = ADDR_W_DEF;

endpackage

// File: rtl/io_addr_gen.sv
// Loadable write-address counter plus remaining-row down-counter.
module io_addr_gen
  import io_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_addr,
  input  logic [ADDR_W-1:0] base,
  input  logic              load_cnt,
  input  logic [ADDR_W-1:0] len,
  input  logic              step,
  output logic [ADDR_W-1:0] addr,
  output logic              last
);

  localparam logic [ADDR_W-1:0] ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  logic [ADDR_W-1:0] addr_r;
  logic [ADDR_W-1:0] rem_r;

  // Address and remaining-count registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_r <= {ADDR_W{1'b0}};
      rem_r  <= {ADDR_W{1'b0}};
    end else begin
      if (load_addr) begin
        addr_r <= base;
      end else if (step) begin
        addr_r <= addr_r + ONE;
      end
      if (load_cnt) begin
        rem_r <= len;
      end else if (step) begin
        rem_r <= rem_r - ONE;
      end
    end
  end

  assign addr = addr_r;
  assign last = (rem_r == ONE);

endmodule

// File: rtl/io_row_writer.sv
// Accepts a header plus decompressed rows and writes the rows sequentially
// into the selected CNN memory region (weights or image).
module io_row_writer
  import io_pkg::*;
#(
  parameter int ROW_SIZE = 16,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int CNN_BASE = CNN_BASE_DEF,
  parameter int IMG_BASE = 2 ** (ADDR_W - 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                cnn_img,
  input  logic                interrupt,
  input  logic                row_valid,
  input  logic [ROW_SIZE-1:0] row_data,
  output logic                row_ready,
  input  logic                mem_busy,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [ROW_SIZE-1:0] mem_wdata,
  output logic                busy,
  output logic                done,
  output logic                err
);

  localparam logic [ADDR_W-1:0] CNN_BASE_V  = ADDR_W'(CNN_BASE);
  localparam logic [ADDR_W-1:0] IMG_BASE_V  = ADDR_W'(IMG_BASE);
  localparam logic [ADDR_W:0]   REGION_ROWS = (ADDR_W + 1)'(2 ** (ADDR_W - 1));

  state_t              state_r, next_s;
  logic                row_ready_s;
  logic                accept_s;
  logic                start_go_s;
  logic                hdr_acc_s;
  logic                wr_acc_s;
  logic                len_bad_s;
  logic [ADDR_W-1:0]   len_s;
  logic [ADDR_W-1:0]   base_s;
  logic [ADDR_W-1:0]   addr_s;
  logic                last_s;

  logic                mem_we_r;
  logic [ADDR_W-1:0]   mem_addr_r;
  logic [ROW_SIZE-1:0] mem_wdata_r;
  logic                busy_r;
  logic                done_r;
  logic                err_r;

  assign len_s     = row_data[ADDR_W-1:0];
  assign len_bad_s = (len_s == {ADDR_W{1'b0}}) || ({1'b0, len_s} > REGION_ROWS);
  assign base_s    = cnn_img ? IMG_BASE_V : CNN_BASE_V;

  // Handshake decode and next-state logic; interrupt overrides everything.
  always_comb begin
    next_s      = state_r;
    row_ready_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start && !interrupt) begin
          next_s = ST_HEADER;
        end else begin
          next_s = ST_IDLE;
        end
      end
      ST_HEADER: begin
        row_ready_s = !interrupt;
        if (interrupt) begin
          next_s = ST_IDLE;
        end else if (row_valid) begin
          next_s = len_bad_s ? ST_DONE : ST_WRITE;
        end else begin
          next_s = ST_HEADER;
        end
      end
      ST_WRITE: begin
        row_ready_s = !mem_busy && !interrupt;
        if (interrupt) begin
          next_s = ST_IDLE;
        end else if (row_valid && !mem_busy && last_s) begin
          next_s = ST_DONE;
        end else begin
          next_s = ST_WRITE;
        end
      end
      ST_DONE: begin
        next_s = ST_IDLE;
      end
      default: begin
        next_s = ST_IDLE;
      end
    endcase
  end

  assign accept_s   = row_valid && row_ready_s;
  assign start_go_s = (state_r == ST_IDLE) && start && !interrupt;
  assign hdr_acc_s  = (state_r == ST_HEADER) && accept_s;
  assign wr_acc_s   = (state_r == ST_WRITE) && accept_s;

  io_addr_gen #(
    .ADDR_W (ADDR_W)
  ) u_addr_gen (
    .clk       (clk),
    .rst       (rst),
    .load_addr (start_go_s),
    .base      (base_s),
    .load_cnt  (hdr_acc_s && !len_bad_s),
    .len       (len_s),
    .step      (wr_acc_s),
    .addr      (addr_s),
    .last      (last_s)
  );

  // State and registered outputs; the write lands one cycle after its accept.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r     <= ST_IDLE;
      mem_we_r    <= 1'b0;
      mem_addr_r  <= {ADDR_W{1'b0}};
      mem_wdata_r <= {ROW_SIZE{1'b0}};
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      err_r       <= 1'b0;
    end else begin
      state_r  <= next_s;
      mem_we_r <= wr_acc_s;
      if (wr_acc_s) begin
        mem_addr_r  <= addr_s;
        mem_wdata_r <= row_data;
      end
      busy_r <= (next_s != ST_IDLE);
      done_r <= (next_s == ST_DONE);
      if (start_go_s) begin
        err_r <= 1'b0;
      end else if (hdr_acc_s && len_bad_s) begin
        err_r <= 1'b1;
      end
    end
  end

  assign row_ready = row_ready_s;
  assign mem_we    = mem_we_r;
  assign mem_addr  = mem_addr_r;
  assign mem_wdata = mem_wdata_r;
  assign busy      = busy_r;
  assign done      = done_r;
  assign err       = err_r;

endmodule

// File: tb/tb_io_row_writer.sv
// Scoreboard bench for io_row_writer: directed transfers push expected
// writes/done pulses; a negedge monitor pops and compares.
module tb_io_row_writer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        cnn_img;
  logic        interrupt;
  logic        row_valid;
  logic [15:0] row_data;
  logic        row_ready;
  logic        mem_busy;
  logic        mem_we;
  logic [9:0]  mem_addr;
  logic [15:0] mem_wdata;
  logic        busy;
  logic        done;
  logic        err;

  typedef struct {
    logic [9:0]  addr;
    logic [15:0] data;
    logic        last;
  } wr_t;

  wr_t  wr_q[$];
  logic done_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  io_row_writer dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .cnn_img   (cnn_img),
    .interrupt (interrupt),
    .row_valid (row_valid),
    .row_data  (row_data),
    .row_ready (row_ready),
    .mem_busy  (mem_busy),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every write and every done pulse must match a queued expectation.
  wr_t w;
  always @(negedge clk) begin
    if (rst) begin
      if (mem_we) begin
        if (wr_q.size() == 0) begin
          check("unexpected_write", {22'd0, mem_addr}, 32'hFFFF_FFFF);
        end else begin
          w = wr_q.pop_front();
          check("wr_addr", {22'd0, mem_addr}, {22'd0, w.addr});
          check("wr_data", {16'd0, mem_wdata}, {16'd0, w.data});
          check("done_with_write", {31'd0, done}, {31'd0, w.last});
          if (w.last) check("err_on_good_done", {31'd0, err}, 32'd0);
        end
      end else if (done) begin
        if (done_q.size() == 0) begin
          check("unexpected_done", 32'd1, 32'd0);
        end else begin
          check("err_on_done", {31'd0, err}, {31'd0, done_q.pop_front()});
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic img);
    start   = 1'b1;
    cnn_img = img;
    tick();
    start = 1'b0;
    check("busy_after_start", {31'd0, busy}, 32'd1);
    check("err_clear_on_start", {31'd0, err}, 32'd0);
  endtask

  task automatic send(input logic [15:0] d);
    logic acc;
    int   n;
    row_valid = 1'b1;
    row_data  = d;
    acc = 1'b0;
    n   = 0;
    while (!acc && n < 50) begin
      @(negedge clk);
      acc = row_ready;
      tick();
      n++;
    end
    if (!acc) check("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic push_wr(input logic [9:0] a, input logic [15:0] d, input logic l);
    wr_t e;
    e.addr = a;
    e.data = d;
    e.last = l;
    wr_q.push_back(e);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_row_ready"}, {31'd0, row_ready}, 32'd0);
    check({tag, "_mem_we"}, {31'd0, mem_we}, 32'd0);
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    check({tag, "_done"}, {31'd0, done}, 32'd0);
    check({tag, "_err"}, {31'd0, err}, 32'd0);
    check({tag, "_mem_addr"}, {22'd0, mem_addr}, 32'd0);
    check({tag, "_mem_wdata"}, {16'd0, mem_wdata}, 32'd0);
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; cnn_img = 1'b0; interrupt = 1'b0;
    row_valid = 1'b0; row_data = 16'd0; mem_busy = 1'b0;
    #2;
    check_all_zero("reset");
    #10 rst = 1'b1;
    tick();

    // Weight transfer of three rows with valid held high.
    do_start(1'b0);
    push_wr(10'd0, 16'hAAAA, 1'b0);
    push_wr(10'd1, 16'hBBBB, 1'b0);
    push_wr(10'd2, 16'hCCCC, 1'b1);
    send(16'd3); send(16'hAAAA); send(16'hBBBB); send(16'hCCCC);
    row_valid = 1'b0;
    check("t1_done_pulse", {31'd0, done}, 32'd1);
    tick();
    check("t1_done_once", {31'd0, done}, 32'd0);
    check("t1_idle", {31'd0, busy}, 32'd0);

    // Image region, single row; upper header bits must be ignored.
    do_start(1'b1);
    push_wr(10'd512, 16'hBEEF, 1'b1);
    send(16'hFC01); send(16'hBEEF);
    row_valid = 1'b0;
    tick(); tick();

    // Backpressure for four cycles mid-transfer.
    do_start(1'b0);
    for (int i = 0; i < 4; i++) push_wr(10'(i), 16'h1000 + 16'(i), (i == 3));
    send(16'd4); send(16'h1000); send(16'h1001);
    mem_busy = 1'b1;
    row_data = 16'h1002;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("bp_row_ready", {31'd0, row_ready}, 32'd0);
      tick();
    end
    mem_busy = 1'b0;
    send(16'h1002); send(16'h1003);
    row_valid = 1'b0;
    tick(); tick();

    // Bad headers: zero length, then one row beyond the region size.
    do_start(1'b0);
    done_q.push_back(1'b1);
    send(16'd0);
    row_valid = 1'b0;
    check("hdr0_err", {31'd0, err}, 32'd1);
    tick();
    check("hdr0_err_sticky", {31'd0, err}, 32'd1);
    do_start(1'b1);
    done_q.push_back(1'b1);
    send(16'd513);
    row_valid = 1'b0;
    check("hdr513_err", {31'd0, err}, 32'd1);
    tick(); tick();

    // Abort after two of five rows, then restart at the region base.
    do_start(1'b0);
    push_wr(10'd0, 16'h5000, 1'b0);
    push_wr(10'd1, 16'h5001, 1'b0);
    send(16'd5); send(16'h5000); send(16'h5001);
    interrupt = 1'b1;
    row_data  = 16'h5002;
    @(negedge clk);
    check("abort_row_ready", {31'd0, row_ready}, 32'd0);
    tick();
    interrupt = 1'b0;
    row_valid = 1'b0;
    check("abort_idle", {31'd0, busy}, 32'd0);
    tick(); tick();
    do_start(1'b0);
    push_wr(10'd0, 16'h6000, 1'b1);
    send(16'd1); send(16'h6000);
    row_valid = 1'b0;
    tick(); tick();

    // Asynchronous reset in the middle of a write transfer.
    do_start(1'b0);
    push_wr(10'd0, 16'h7000, 1'b0);
    send(16'd3); send(16'h7000);
    row_data = 16'h7001;
    @(negedge clk);
    #1 rst = 1'b0;
    #1;
    check_all_zero("async_rst");
    row_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    check("post_rst_idle", {31'd0, busy}, 32'd0);
    do_start(1'b1);
    push_wr(10'd512, 16'h8000, 1'b1);
    send(16'd1); send(16'h8000);
    row_valid = 1'b0;
    tick(); tick(); tick();

    check("wr_q_drained", wr_q.size(), 32'd0);
    check("done_q_drained", done_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
